pipelined_csel_adder: RTL and testbench



---
 rtl/pipelined_csel_adder.sv | 162 ++++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: WIDTH-bit add/subtract built from BLOCK-bit
// carry-select blocks spread over STAGES register stages, with valid/ready
// handshakes on both sides.
// Optional feature macro: PIPELINED_CSEL_ADDER_SATURATE_EN clamps S to the
// signed extreme on overflow. Cout and Overflow are not affected.
module pipelined_csel_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned NBLK = WIDTH / BLOCK;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_S;
    logic             r_Cout;
    logic             r_Overflow;
    logic             w_advance;

    // The whole pipeline moves together. It stalls only when a finished
    // result is waiting at the output and nobody takes it.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned SI = s;

        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_sin;
        logic [WIDTH-1:0] w_sout;
        logic             w_cin;
        logic             w_cout;
        logic             w_vin;
        logic [BLOCK:0]   w_lo;
        logic [BLOCK:0]   w_hi;
        logic [BLOCK:0]   w_sel;
        logic             w_c;

        if (s == 0) begin : g_src
            // b is inverted for subtraction. The carry-in then becomes the
            // inverted borrow-in.
            assign w_a   = a;
            assign w_b   = b ^ {WIDTH{sub}};
            assign w_sin = '0;
            assign w_cin = Cin ^ sub;
            assign w_vin = in_valid;
        end else begin : g_src
            assign w_a   = g_stage[s-1].g_reg.r_a;
            assign w_b   = g_stage[s-1].g_reg.r_b;
            assign w_sin = g_stage[s-1].g_reg.r_s;
            assign w_cin = g_stage[s-1].g_reg.r_c;
            assign w_vin = g_stage[s-1].g_reg.r_v;
        end

        // Resolve the carry-select blocks owned by this stage. The incoming
        // carry picks the precomputed carry-0 or carry-1 sum for each block.
        always_comb begin
            w_sout = w_sin;
            w_c    = w_cin;
            w_lo   = '0;
            w_hi   = '0;
            w_sel  = '0;
            for (int unsigned i = 0; i < NBLK; i++) begin
                if ((i * STAGES) / NBLK == SI) begin
                    w_lo  = {1'b0, w_a[i*BLOCK +: BLOCK]} + {1'b0, w_b[i*BLOCK +: BLOCK]};
                    w_hi  = {1'b0, w_a[i*BLOCK +: BLOCK]} + {1'b0, w_b[i*BLOCK +: BLOCK]}
                            + {{BLOCK{1'b0}}, 1'b1};
                    w_sel = w_c ? w_hi : w_lo;
                    w_sout[i*BLOCK +: BLOCK] = w_sel[BLOCK-1:0];
                    w_c   = w_sel[BLOCK];
                end
            end
            w_cout = w_c;
        end

        if (s < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_s;
            logic             r_c;
            logic             r_v;

            // Stage boundary register. Data loads only for valid
            // transactions. Bubbles pass through the valid bit alone.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                    r_c <= 1'b0;
                end else if (w_advance) begin
                    r_v <= w_vin;
                    if (w_vin) begin
                        r_a <= w_a;
                        r_b <= w_b;
                        r_s <= w_sout;
                        r_c <= w_cout;
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
`ifdef PIPELINED_CSEL_ADDER_SATURATE_EN
    logic [WIDTH-1:0] w_sat;
`endif

    // Final result. Signed overflow is the carry into the MSB XOR the carry
    // out. The carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        w_ovf = g_stage[STAGES-1].w_sout[WIDTH-1] ^ g_stage[STAGES-1].w_a[WIDTH-1]
              ^ g_stage[STAGES-1].w_b[WIDTH-1] ^ g_stage[STAGES-1].w_cout;
`ifdef PIPELINED_CSEL_ADDER_SATURATE_EN
        w_sat = g_stage[STAGES-1].w_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
        w_res = w_ovf ? w_sat : g_stage[STAGES-1].w_sout;
`else
        w_res = g_stage[STAGES-1].w_sout;
`endif
    end

    // Output register. It holds its value while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_S         <= '0;
            r_Cout      <= 1'b0;
            r_Overflow  <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= g_stage[STAGES-1].w_vin;
            if (g_stage[STAGES-1].w_vin) begin
                r_S        <= w_res;
                r_Cout     <= g_stage[STAGES-1].w_cout;
                r_Overflow <= w_ovf;
            end
        end
    end

    assign S         = r_S;
    assign Cout      = r_Cout;
    assign Overflow  = r_Overflow;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder. The default instance runs a
// directed table, several hand-written handshake sequences and a random
// backpressure run. Two extra instances sweep other WIDTH/BLOCK/STAGES
// settings.
module tb_pipelined_csel_adder;

`ifdef PIPELINED_CSEL_ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a, b, S;
    logic        Cin, sub, in_valid, in_ready, Cout, Overflow, out_valid, out_ready;

    logic [15:0] a16, b16, S16;
    logic        c16, sb16, iv16, ir16, co16, ov16, vo16;
    logic [63:0] a64, b64, S64;
    logic        c64, sb64, iv64, ir64, co64, ov64, vo64;
    logic        or_one;

    pipelined_csel_adder u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .Cin(Cin), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .S(S), .Cout(Cout),
        .Overflow(Overflow), .out_valid(out_valid), .out_ready(out_ready));

    pipelined_csel_adder #(.WIDTH(16), .BLOCK(4), .STAGES(4)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .Cin(c16), .sub(sb16),
        .in_valid(iv16), .in_ready(ir16), .S(S16), .Cout(co16),
        .Overflow(ov16), .out_valid(vo16), .out_ready(or_one));

    pipelined_csel_adder #(.WIDTH(64), .BLOCK(8), .STAGES(1)) u_w64 (
        .clk(clk), .rst(rst), .a(a64), .b(b64), .Cin(c64), .sub(sb64),
        .in_valid(iv64), .in_ready(ir64), .S(S64), .Cout(co64),
        .Overflow(ov64), .out_valid(vo64), .out_ready(or_one));

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built from integer arithmetic: an unsigned sum for S
    // and Cout, and a signed true result for the overflow range check.
    function automatic void ref_add(input int unsigned w, input logic [63:0] x, input logic [63:0] y,
                                    input logic ci, input logic sb,
                                    output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] m;
        logic [71:0] ux, uy, ut, uc;
        logic signed [71:0] sx, sy, st, sc, smax, smin;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ux = {8'd0, x & m};
        uy = {8'd0, y & m};
        uc = {71'd0, ci};
        sc = {71'd0, ci};
        sx = $signed(ux << (72 - w)) >>> (72 - w);
        sy = $signed(uy << (72 - w)) >>> (72 - w);
        if (!sb) begin
            ut = ux + uy + uc;
            co = ut[w];
            st = sx + sy + sc;
        end else begin
            ut = ux - uy - uc;
            co = (ux >= uy + uc);
            st = sx - sy - sc;
        end
        s    = ut[63:0] & m;
        smax = (72'sd1 <<< (w - 1)) - 72'sd1;
        smin = -(72'sd1 <<< (w - 1));
        ov   = (st > smax) || (st < smin);
        if (SAT && ov) s = x[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
    endfunction

    function automatic logic [63:0] rnd(input int unsigned w);
        logic [63:0] m, r;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = 64'd1 << (w - 1);
            3: r = (64'd1 << (w - 1)) - 64'd1;
            default: ;
        endcase
        return r & m;
    endfunction

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sb;
        logic [31:0] s;
        logic        co, ov;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        co, ov;
    } exp_t;

    vec_t tbl[11];
    exp_t q[$];

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        a = v.a; b = v.b; Cin = v.cin; sub = v.sb; in_valid = 1'b1;
        #1 chk($sformatf("tbl%0d in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("tbl%0d latency", idx), lat, 2);
        chk($sformatf("tbl%0d result", idx), {out_valid, Cout, Overflow, S}, {1'b1, v.co, v.ov, v.s});
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
        a = x; b = y; Cin = ci; sub = sb; in_valid = 1'b1;
    endtask

    localparam int N = 1000;
    logic [65:0] e16[N];
    logic [65:0] e64[N];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rs;
        logic rco, rov;
        logic held;
        logic [31:0] held_s;
        exp_t e;
        int idx;

        tbl[0]  = '{32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1};
        tbl[1]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[2]  = '{32'd5, 32'd3, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0};
        tbl[3]  = '{32'd5, 32'd3, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0};
        tbl[4]  = '{32'd100, 32'd50, 1'b1, 1'b0, 32'd151, 1'b0, 1'b0};
        tbl[5]  = '{32'hFFFFFFE2, 32'd40, 1'b1, 1'b0, 32'd11, 1'b1, 1'b0};
        tbl[6]  = '{32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
        tbl[7]  = '{32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
        tbl[8]  = '{32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0};
        tbl[9]  = '{32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[10] = '{32'h80000000, 32'd1, 1'b0, 1'b1, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1};

        rst = 1'b1; a = '0; b = '0; Cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a16 = '0; b16 = '0; c16 = 1'b0; sb16 = 1'b0; iv16 = 1'b0;
        a64 = '0; b64 = '0; c64 = 1'b0; sb64 = 1'b0; iv64 = 1'b0; or_one = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("reset outputs", {out_valid, Cout, Overflow, S}, '0);
        #1 chk("reset in_ready", in_ready, 1);
        chk("reset sweep valids", {vo16, vo64}, 2'b00);

        // directed table
        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // back-to-back stream
        @(negedge clk); drive(32'd100, 32'd50, 1'b1, 1'b0);
        @(negedge clk); drive(32'hFFFFFFE2, 32'd40, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b r0", {out_valid, Cout, Overflow, S}, {3'b100, 32'd151});
        drive(32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b r1", {out_valid, Cout, Overflow, S}, {3'b110, 32'd11});
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b r2", {out_valid, Cout, Overflow, S}, {3'b100, 32'd1});
        @(negedge clk);
        chk("b2b drained", out_valid, 0);

        // backpressure with two transactions in flight
        @(negedge clk); drive(32'd1234, 32'd4321, 1'b0, 1'b0);
        @(negedge clk); drive(32'd1000, 32'd1, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp first", {out_valid, Cout, S}, {2'b10, 32'd5555});
        in_valid = 1'b0; out_ready = 1'b0;
        #1 chk("bp in_ready low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk($sformatf("bp stall%0d in_ready", i), in_ready, 0);
            chk($sformatf("bp stall%0d hold", i), {out_valid, Cout, S}, {2'b10, 32'd5555});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp second", {out_valid, Cout, Overflow, S}, {3'b110, 32'd999});
        @(negedge clk);
        chk("bp drained", out_valid, 0);

        // reset with two transactions in flight
        @(negedge clk); drive(32'd7, 32'd8, 1'b0, 1'b0);
        @(negedge clk); drive(32'd9, 32'd10, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst outputs", {out_valid, Cout, Overflow, S}, '0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("midrst quiet%0d", i), out_valid, 0);
        end

        // random traffic with random backpressure against the queue model
        held = 1'b0; held_s = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (held) chk("rand hold", {out_valid, S}, {1'b1, held_s});
            a = rnd(32); b = rnd(32); Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rand spurious", out_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("rand result", {Cout, Overflow, S}, {e.co, e.ov, e.s});
                end
            end
            held = out_valid && !out_ready;
            held_s = S;
            if (in_valid && in_ready) begin
                ref_add(32, {32'd0, a}, {32'd0, b}, Cin, sub, rs, rco, rov);
                e.s = rs[31:0]; e.co = rco; e.ov = rov;
                q.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            #1;
            if (out_valid) begin
                e = q.pop_front();
                chk("drain result", {Cout, Overflow, S}, {e.co, e.ov, e.s});
            end
            @(negedge clk);
        end
        chk("drain empty", q.size(), 0);

        // parameter sweep: streaming input, fixed latency per instance
        for (int c = 0; c < N + 5; c++) begin
            @(negedge clk);
            idx = c - 4;
            if (idx >= 0 && idx < N) chk("w16 result", {vo16, co16, ov16, S16}, {1'b1, e16[idx][65:64], e16[idx][15:0]});
            else chk("w16 idle", vo16, 0);
            idx = c - 1;
            if (idx >= 0 && idx < N) chk("w64 result", {vo64, co64, ov64, S64}, {1'b1, e64[idx]});
            else chk("w64 idle", vo64, 0);
            if (c < N) begin
                a16 = rnd(16); b16 = rnd(16); c16 = 1'($urandom_range(0, 1)); sb16 = 1'($urandom_range(0, 1));
                ref_add(16, {48'd0, a16}, {48'd0, b16}, c16, sb16, rs, rco, rov);
                e16[c] = {rco, rov, rs};
                a64 = rnd(64); b64 = rnd(64); c64 = 1'($urandom_range(0, 1)); sb64 = 1'($urandom_range(0, 1));
                ref_add(64, a64, b64, c64, sb64, rs, rco, rov);
                e64[c] = {rco, rov, rs};
                iv16 = 1'b1; iv64 = 1'b1;
            end else begin
                iv16 = 1'b0; iv64 = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
